// File: rtl/lsu_bytelane_pkg.sv
// Shared encodings and lane helpers for the byte-lane load/store unit.
// Helpers work on a 64-bit / 8-lane superset; callers truncate to their width.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   localparam int unsigned MAX_NB = 8;

   function automatic logic align_ok(size_e sz, logic [2:0] off);
      logic ok;
      case (sz)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = (off[0] == 1'b0);
         SZ_W:    ok = (off[1:0] == 2'b00);
         default: ok = (off == 3'b000);
      endcase
      return ok;
   endfunction

   function automatic logic [MAX_NB-1:0] byte_en(size_e sz, logic [2:0] off);
      logic [MAX_NB-1:0] m;
      case (sz)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

   function automatic logic [63:0] extend(logic [63:0] d, size_e sz, logic uns);
      logic [63:0] r;
      case (sz)
         SZ_B:    r = uns ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
         SZ_H:    r = uns ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
         SZ_W:    r = uns ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_bytelane_if.sv
// Request/response handshake bundle between the execute stage and the LSU.
interface lsu_bytelane_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_bytelane_mem_bank.sv
// Single-port word RAM with per-byte write enables and a registered read pipeline.
module lsu_mem_bank #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     we,
   input  logic [DATA_W/8-1:0]      be,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata
);
   localparam int unsigned NB = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // The parent's response register is the final read stage, so only RD_LAT-1 stages live here.
   if (RD_LAT == 1) begin : g_direct
      assign rdata = mem[idx];
   end else begin : g_pipe
      logic [DATA_W-1:0] pipe_q [RD_LAT-1];
      always_ff @(posedge clk) begin
         pipe_q[0] <= mem[idx];
         for (int unsigned s = 1; s < RD_LAT - 1; s++) pipe_q[s] <= pipe_q[s-1];
      end
      assign rdata = pipe_q[RD_LAT-2];
   end

endmodule

// File: rtl/lsu_bytelane.sv
// Load/store unit: decode, error check, one-in-flight FSM, lane select/extend, response regs.
module lsu_bytelane
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   lsu_bytelane_if.slave  bus
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned LG_NB = $clog2(NB);
   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned WI_W  = ADDR_W - LG_NB;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [LG_NB-1:0]  off_q, off_d;
   size_e             sz_q, sz_d;
   logic              uns_q, uns_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [WI_W-1:0]   word_idx;
   logic [LG_NB-1:0]  off;
   size_e             req_sz;
   logic              req_err, accept, mem_en;
   logic [NB-1:0]     be;
   logic [DATA_W-1:0] wdata_sh, bank_rdata, lane_data, load_val;
   logic [LG_NB-1:0]  sel_off;
   size_e             sel_sz;
   logic              sel_uns;

   assign word_idx = bus.req_addr[ADDR_W-1:LG_NB];
   assign off      = bus.req_addr[LG_NB-1:0];
   assign req_sz   = size_e'(bus.req_size);
   assign req_err  = !align_ok(req_sz, 3'(off))
                   || (word_idx >= WI_W'(DEPTH))
                   || ((req_sz == SZ_D) && (DATA_W == 32));
   assign accept   = bus.req_valid && (state_q == IDLE);
   assign mem_en   = accept && !req_err;
   assign be       = NB'(byte_en(req_sz, 3'(off)));
   assign wdata_sh = bus.req_wdata << {off, 3'b000};

   lsu_mem_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) u_bank (
      .clk   (clk),
      .en    (mem_en),
      .we    (bus.req_we),
      .be    (be),
      .idx   (IDX_W'(word_idx)),
      .wdata (wdata_sh),
      .rdata (bank_rdata)
   );

   // Single-cycle loads extract straight from the request; longer ones use the captured fields.
   assign sel_off   = (state_q == IDLE) ? off          : off_q;
   assign sel_sz    = (state_q == IDLE) ? req_sz       : sz_q;
   assign sel_uns   = (state_q == IDLE) ? bus.req_unsigned : uns_q;
   assign lane_data = bank_rdata >> {sel_off, 3'b000};
   assign load_val  = DATA_W'(extend(64'(lane_data), sel_sz, sel_uns));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      off_d   = off_q;
      sz_d    = sz_q;
      uns_d   = uns_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               off_d = off;
               sz_d  = req_sz;
               uns_d = bus.req_unsigned;
               err_d = req_err;
               if (req_err || bus.req_we) begin
                  state_d = RESP;
                  rdata_d = '0;
               end else if (RD_LAT == 1) begin
                  state_d = RESP;
                  rdata_d = load_val;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 3'(RD_LAT - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 3'd1) begin
               state_d = RESP;
               cnt_d   = '0;
               rdata_d = load_val;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         off_q   <= '0;
         sz_q    <= SZ_B;
         uns_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         off_q   <= off_d;
         sz_q    <= sz_d;
         uns_q   <= uns_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu_bytelane.sv
// Directed bench: an RD_LAT=1 and an RD_LAT=3 instance driven from a vector table plus corner sequences.
module tb_lsu_bytelane;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lsu_bytelane_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
   lsu_bytelane_if #(.DATA_W(32), .ADDR_W(32)) if1 ();

   lsu_bytelane #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(1)) u_dut0 (
      .clk (clk), .rst (rst), .bus (if0.slave)
   );
   lsu_bytelane #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(3)) u_dut1 (
      .clk (clk), .rst (rst), .bus (if1.slave)
   );

   logic        rv [2];
   logic        we_v [2];
   logic [1:0]  sz_v [2];
   logic        un_v [2];
   logic [31:0] ad_v [2];
   logic [31:0] wd_v [2];
   logic        rr [2];

   logic        rsp_v [2];
   logic        rsp_e [2];
   logic        req_r [2];
   logic [31:0] rsp_d [2];

   assign if0.req_valid    = rv[0];
   assign if0.req_we       = we_v[0];
   assign if0.req_size     = sz_v[0];
   assign if0.req_unsigned = un_v[0];
   assign if0.req_addr     = ad_v[0];
   assign if0.req_wdata    = wd_v[0];
   assign if0.resp_ready   = rr[0];
   assign if1.req_valid    = rv[1];
   assign if1.req_we       = we_v[1];
   assign if1.req_size     = sz_v[1];
   assign if1.req_unsigned = un_v[1];
   assign if1.req_addr     = ad_v[1];
   assign if1.req_wdata    = wd_v[1];
   assign if1.resp_ready   = rr[1];

   assign rsp_v[0] = if0.resp_valid;
   assign rsp_e[0] = if0.resp_err;
   assign req_r[0] = if0.req_ready;
   assign rsp_d[0] = if0.resp_rdata;
   assign rsp_v[1] = if1.resp_valid;
   assign rsp_e[1] = if1.resp_err;
   assign req_r[1] = if1.req_ready;
   assign rsp_d[1] = if1.resp_rdata;

   int ntests = 0;
   int nfail  = 0;

   typedef struct {
      int          d;
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] er;
      logic        ee;
      int          el;
      string       nm;
   } vec_t;

   vec_t vecs [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void addv(int d, logic w, logic [1:0] sz, logic u, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] er, logic ee, int el, string nm);
      vec_t v;
      v.d = d; v.w = w; v.sz = sz; v.u = u; v.a = a; v.wd = wd;
      v.er = er; v.ee = ee; v.el = el; v.nm = nm;
      vecs.push_back(v);
   endfunction

   // lat = edges after the accept edge before resp_valid is seen (RD_LAT-1 for loads).
   task automatic do_txn(input int d, input logic w, input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] wdat,
                         output logic [31:0] rdat, output logic e, output int lat);
      int guard = 0;
      @(posedge clk); #1;
      while (!req_r[d] && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      rv[d] = 1'b1; we_v[d] = w; sz_v[d] = s; un_v[d] = u; ad_v[d] = a; wd_v[d] = wdat;
      @(posedge clk); #1;
      rv[d] = 1'b0;
      lat = 0;
      while (!rsp_v[d] && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rdat = rsp_d[d];
      e    = rsp_e[d];
      rr[d] = 1'b1;
      @(posedge clk); #1;
      rr[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdat;
      logic        e;
      int          lat;
      int          seen;

      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b0; we_v[i] = 1'b0; sz_v[i] = 2'b00; un_v[i] = 1'b0;
         ad_v[i] = '0; wd_v[i] = '0; rr[i] = 1'b0;
      end

      // dut0: RD_LAT=1
      addv(0, 1, 2'b10, 0, 32'h000, 32'h11223344, 32'h00000000, 0, 0, "sw_00");
      addv(0, 1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 32'h00000000, 0, 0, "sw_10");
      addv(0, 0, 2'b10, 0, 32'h010, 32'h0,        32'hDEADBEEF, 0, 0, "lw_10");
      addv(0, 1, 2'b00, 0, 32'h013, 32'h00000080, 32'h00000000, 0, 0, "sb_13");
      addv(0, 0, 2'b00, 0, 32'h013, 32'h0,        32'hFFFFFF80, 0, 0, "lb_13");
      addv(0, 0, 2'b00, 1, 32'h013, 32'h0,        32'h00000080, 0, 0, "lbu_13");
      addv(0, 0, 2'b10, 0, 32'h010, 32'h0,        32'h80ADBEEF, 0, 0, "lw_10_after_sb");
      addv(0, 0, 2'b01, 0, 32'h012, 32'h0,        32'hFFFF80AD, 0, 0, "lh_12");
      addv(0, 0, 2'b01, 1, 32'h010, 32'h0,        32'h0000BEEF, 0, 0, "lhu_10");
      addv(0, 0, 2'b01, 0, 32'h011, 32'h0,        32'h00000000, 1, 0, "lh_11_misalign");
      addv(0, 1, 2'b10, 0, 32'h400, 32'hCAFEBABE, 32'h00000000, 1, 0, "sw_oor");
      addv(0, 0, 2'b10, 0, 32'h400, 32'h0,        32'h00000000, 1, 0, "lw_oor");
      addv(0, 0, 2'b11, 0, 32'h010, 32'h0,        32'h00000000, 1, 0, "ld_size3");
      addv(0, 0, 2'b10, 0, 32'h000, 32'h0,        32'h11223344, 0, 0, "lw_00_unchanged");
      addv(0, 1, 2'b10, 0, 32'h012, 32'h55555555, 32'h00000000, 1, 0, "sw_misalign");
      addv(0, 1, 2'b10, 0, 32'h014, 32'h00000000, 32'h00000000, 0, 0, "sw_14");
      addv(0, 1, 2'b01, 0, 32'h016, 32'hABCDCAFE, 32'h00000000, 0, 0, "sh_16");
      addv(0, 0, 2'b10, 0, 32'h014, 32'h0,        32'hCAFE0000, 0, 0, "lw_14");
      addv(0, 0, 2'b00, 1, 32'h017, 32'h0,        32'h000000CA, 0, 0, "lbu_17");
      addv(0, 0, 2'b00, 0, 32'h016, 32'h0,        32'hFFFFFFFE, 0, 0, "lb_16");
      addv(0, 0, 2'b10, 0, 32'h016, 32'h0,        32'h00000000, 1, 0, "lw_16_misalign");
      addv(0, 1, 2'b10, 0, 32'h3FC, 32'h01020304, 32'h00000000, 0, 0, "sw_3fc");
      addv(0, 1, 2'b00, 0, 32'h3FF, 32'h0000007F, 32'h00000000, 0, 0, "sb_3ff");
      addv(0, 0, 2'b10, 0, 32'h3FC, 32'h0,        32'h7F020304, 0, 0, "lw_3fc");
      addv(0, 0, 2'b00, 0, 32'h3FF, 32'h0,        32'h0000007F, 0, 0, "lb_3ff");
      // dut1: RD_LAT=3
      addv(1, 1, 2'b10, 0, 32'h020, 32'hA5A50F0F, 32'h00000000, 0, 0, "l3_sw_20");
      addv(1, 0, 2'b10, 0, 32'h020, 32'h0,        32'hA5A50F0F, 0, 2, "l3_lw_20");
      addv(1, 0, 2'b00, 0, 32'h021, 32'h0,        32'h0000000F, 0, 2, "l3_lb_21");
      addv(1, 0, 2'b01, 1, 32'h022, 32'h0,        32'h0000A5A5, 0, 2, "l3_lhu_22");
      addv(1, 0, 2'b01, 0, 32'h022, 32'h0,        32'hFFFFA5A5, 0, 2, "l3_lh_22");
      addv(1, 0, 2'b01, 0, 32'h021, 32'h0,        32'h00000000, 1, 0, "l3_lh_21_err");

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_valid0", 32'(rsp_v[0]), 32'h0);
      chk("rst_resp_valid1", 32'(rsp_v[1]), 32'h0);
      chk("rst_rdata0", rsp_d[0], 32'h0);
      chk("rst_err0", 32'(rsp_e[0]), 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_req_ready0", 32'(req_r[0]), 32'h1);
      chk("rst_req_ready1", 32'(req_r[1]), 32'h1);

      foreach (vecs[i]) begin
         do_txn(vecs[i].d, vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rdat, e, lat);
         chk({vecs[i].nm, "_rdata"}, rdat, vecs[i].er);
         chk({vecs[i].nm, "_err"}, 32'(e), 32'(vecs[i].ee));
         chk({vecs[i].nm, "_lat"}, 32'(lat), 32'(vecs[i].el));
      end

      // Stall: response held with resp_ready low, competing request must be ignored
      @(posedge clk); #1;
      rv[0] = 1'b1; we_v[0] = 1'b0; sz_v[0] = 2'b10; un_v[0] = 1'b0; ad_v[0] = 32'h010;
      @(posedge clk); #1;
      chk("stall_valid_first", 32'(rsp_v[0]), 32'h1);
      we_v[0] = 1'b1; wd_v[0] = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(rsp_v[0]), 32'h1);
         chk("stall_rdata", rsp_d[0], 32'h80ADBEEF);
         chk("stall_err", 32'(rsp_e[0]), 32'h0);
         chk("stall_req_ready", 32'(req_r[0]), 32'h0);
      end
      rv[0] = 1'b0; rr[0] = 1'b1;
      @(posedge clk); #1;
      rr[0] = 1'b0;
      chk("stall_released", 32'(rsp_v[0]), 32'h0);
      do_txn(0, 0, 2'b10, 0, 32'h010, 32'h0, rdat, e, lat);
      chk("stall_store_ignored", rdat, 32'h80ADBEEF);

      // Reset during a WAIT load on the RD_LAT=3 instance
      @(posedge clk); #1;
      rv[1] = 1'b1; we_v[1] = 1'b0; sz_v[1] = 2'b10; un_v[1] = 1'b0; ad_v[1] = 32'h020;
      @(posedge clk); #1;
      rv[1] = 1'b0;
      chk("wait_valid_low", 32'(rsp_v[1]), 32'h0);
      chk("wait_req_ready_low", 32'(req_r[1]), 32'h0);
      chk("pre_rst_rdata_held", rsp_d[1], 32'h0000FFFF & 32'h0);
      rst = 1'b0;
      #1;
      chk("midrst_valid", 32'(rsp_v[1]), 32'h0);
      chk("midrst_rdata", rsp_d[1], 32'h0);
      chk("midrst_err", 32'(rsp_e[1]), 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("postrst_req_ready", 32'(req_r[1]), 32'h1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_v[1]) seen++;
         @(posedge clk); #1;
      end
      chk("postrst_no_resp", 32'(seen), 32'h0);
      do_txn(1, 0, 2'b10, 0, 32'h020, 32'h0, rdat, e, lat);
      chk("postrst_mem_kept", rdat, 32'hA5A50F0F);
      chk("postrst_lat", 32'(lat), 32'd2);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
